clk_div_multi: RTL and testbench

Multi-channel programmable clock-enable generator, successor to the fixed single-ratio divider. Each of CH_NUM channels divides sys_clk by a divide value loaded at run time, producing a one-cycle clk_flag strobe and a near-50% square wave clk_out. Channels can free-run or fire once (one-shot), and can be realigned together. The block sits beside the system clock source and feeds enable strobes to downstream timers, UART baud logic and LED/PWM blocks.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_chan.sv | 94 +++++++++
 rtl/clk_div_multi.sv | 66 ++++++
 tb/tb_clk_div_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared mode type and constants for the multi-channel clock divider
package clk_div_pkg;

    typedef enum logic {
        MODE_FREE    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    localparam int DIV_MIN   = 2;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, shadow config, one-shot done, output registers
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync_clr,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    input  mode_e            i_mode,
    output logic             o_pend,
    output logic             o_flag,
    output logic             o_out
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_sh_div;
    mode_e            r_mode;
    mode_e            r_sh_mode;
    logic             r_pend;
    logic             r_done;
    logic             r_flag;
    logic             r_out;

    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] w_div_n;
    mode_e            w_mode_n;
    logic             w_done_n;
    logic             w_pend_n;
    logic             w_apply;
    logic             w_tc;

    assign w_tc = (r_cnt == r_div - CNT_W'(1));

    // Shadow config only lands at period boundaries so no runt pulses appear.
    always_comb begin
        w_cnt_n  = r_cnt;
        w_done_n = r_done;
        w_apply  = 1'b0;
        if (!i_en || i_sync_clr) begin
            w_cnt_n  = '0;
            w_done_n = 1'b0;
            w_apply  = r_pend;
        end else if (r_done) begin
            w_apply  = r_pend;
        end else if (w_tc) begin
            w_cnt_n  = '0;
            w_done_n = (r_mode == MODE_ONESHOT);
            w_apply  = r_pend;
        end else begin
            w_cnt_n  = r_cnt + CNT_W'(1);
        end
        w_div_n  = w_apply ? r_sh_div  : r_div;
        w_mode_n = w_apply ? r_sh_mode : r_mode;
        w_pend_n = i_wr | (r_pend & ~w_apply);
    end

    // Outputs are registered from next state so they line up with the counter value they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= CNT_W'(DIV_DEFAULT);
            r_mode    <= MODE_FREE;
            r_sh_div  <= CNT_W'(DIV_DEFAULT);
            r_sh_mode <= MODE_FREE;
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
            r_flag    <= 1'b0;
            r_out     <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_n;
            r_div  <= w_div_n;
            r_mode <= w_mode_n;
            r_pend <= w_pend_n;
            r_done <= w_done_n;
            r_flag <= ~w_done_n & (w_cnt_n == w_div_n - CNT_W'(1));
            r_out  <= ~w_done_n & (w_cnt_n >= (w_div_n >> 1));
            if (i_wr) begin
                r_sh_div  <= i_div;
                r_sh_mode <= i_mode;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_flag = r_flag;
    assign o_out  = r_out;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock-enable generator top
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int CH_NUM      = 4,
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int DIV_DEFAULT = 6,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic              cfg_err,
    output logic [CH_NUM-1:0] clk_flag,
    output logic [CH_NUM-1:0] clk_out
);

    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_NUM);

    logic [CH_NUM-1:0] w_pend;
    logic              w_ch_ok;
    logic              w_xfer;
    logic              w_cfg_ok;
    logic              r_err;

    // Out-of-range channels report ready so the request completes and is flagged as an error.
    assign w_ch_ok   = ({1'b0, cfg_ch} < CH_LIM);
    assign cfg_ready = w_ch_ok ? ~w_pend[cfg_ch] : 1'b1;
    assign w_xfer    = cfg_valid & cfg_ready;
    assign w_cfg_ok  = w_ch_ok & (cfg_div >= CNT_W'(DIV_MIN));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_cfg_ok;
        end
    end

    assign cfg_err = r_err;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .clk        (sys_clk),
            .rst        (sys_rst),
            .i_en       (ch_en[g]),
            .i_sync_clr (sync_clr),
            .i_wr       (w_xfer & w_cfg_ok & (cfg_ch == CH_W'(g))),
            .i_div      (cfg_div),
            .i_mode     (cfg_oneshot ? MODE_ONESHOT : MODE_FREE),
            .o_pend     (w_pend[g]),
            .o_flag     (clk_flag[g]),
            .o_out      (clk_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized bench with behavioural model for clk_div_multi
module tb_clk_div_multi;

    localparam int N   = 5;
    localparam int CW  = 8;
    localparam int CHW = 3;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b0;
    logic [N-1:0]   ch_en = '0;
    logic           sync_clr = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_oneshot = 1'b0;
    logic           cfg_err;
    logic [N-1:0]   clk_flag;
    logic [N-1:0]   clk_out;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_multi #(
        .CH_NUM      (N),
        .CNT_W       (CW),
        .DIV_DEFAULT (6)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .ch_en       (ch_en),
        .sync_clr    (sync_clr),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .cfg_err     (cfg_err),
        .clk_flag    (clk_flag),
        .clk_out     (clk_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase within the current period, active/shadow ratio and mode.
    int m_ph[N];
    int m_div[N];
    int m_sdiv[N];
    bit m_one[N];
    bit m_sone[N];
    bit m_done[N];
    bit m_pend[N];
    bit m_err;

    function automatic bit m_ready(input int ch);
        return (ch < N) ? !m_pend[ch] : 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ph[i] = 0; m_div[i] = 6; m_sdiv[i] = 6;
            m_one[i] = 0; m_sone[i] = 0; m_done[i] = 0; m_pend[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_edge();
        int ch;
        bit xfer, good, app;
        ch   = int'(cfg_ch);
        xfer = cfg_valid && m_ready(ch);
        good = (ch < N) && (int'(cfg_div) >= 2);
        for (int i = 0; i < N; i++) begin
            app = 0;
            if (!ch_en[i] || sync_clr) begin
                m_ph[i] = 0; m_done[i] = 0; app = m_pend[i];
            end else if (m_done[i]) begin
                app = m_pend[i];
            end else if (m_ph[i] == m_div[i] - 1) begin
                m_ph[i] = 0; m_done[i] = m_one[i]; app = m_pend[i];
            end else begin
                m_ph[i]++;
            end
            if (app) begin
                m_div[i] = m_sdiv[i]; m_one[i] = m_sone[i]; m_pend[i] = 0;
            end
        end
        if (xfer && good) begin
            m_sdiv[ch] = int'(cfg_div); m_sone[ch] = cfg_oneshot; m_pend[ch] = 1;
        end
        m_err = xfer && !good;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) model_reset();
            else         model_edge();
        end
    end

    initial begin
        logic [N-1:0] ef, eo;
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < N; i++) begin
                ef[i] = !m_done[i] && (m_ph[i] == m_div[i] - 1);
                eo[i] = !m_done[i] && (m_ph[i] >= m_div[i] / 2);
            end
            check("clk_flag", 32'(clk_flag), 32'(ef));
            check("clk_out", 32'(clk_out), 32'(eo));
            check("cfg_err", 32'(cfg_err), 32'(m_err));
            check("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int div, input bit one);
        cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_div = CW'(div); cfg_oneshot = one;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic count_flags(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (clk_flag[ch]) cnt++;
        end
    endtask

    // Release reset with all channels on and pin the default 6-cycle waveform literally.
    task automatic release_and_check_default(input string tag);
        logic [11:0] pat_out, pat_flag;
        pat_out  = 12'h71C;
        pat_flag = 12'h410;
        sys_rst = 1'b0;
        ch_en   = '1;
        for (int k = 0; k < 12; k++) begin
            step();
            check({tag, "_out"},  32'(clk_out),  pat_out[k]  ? 32'h1F : 32'h0);
            check({tag, "_flag"}, 32'(clk_flag), pat_flag[k] ? 32'h1F : 32'h0);
        end
    endtask

    initial begin
        int cnt, p, lows;
        bit found;

        sys_rst = 1'b1;
        repeat (3) step();
        release_and_check_default("default");

        cfg_write(1, 5, 1'b0);
        check("ready_ch1_pending", 32'(cfg_ready), 32'h0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            found = clk_flag[1];
        end
        check("ch1_old_period_flag", 32'(found), 32'h1);
        p = 0; lows = 0; found = 0;
        while (!found && p < 12) begin
            step();
            p++;
            if (!clk_out[1]) lows++;
            found = clk_flag[1];
        end
        check("ch1_new_period", 32'(p), 32'd5);
        check("ch1_low_cycles", 32'(lows), 32'd2);
        check("ready_ch1_applied", 32'(cfg_ready), 32'h1);

        cfg_write(0, 1, 1'b0);
        check("err_div1", 32'(cfg_err), 32'h1);
        step();
        check("err_div1_one_cycle", 32'(cfg_err), 32'h0);
        cfg_write(5, 7, 1'b0);
        check("err_ch5", 32'(cfg_err), 32'h1);
        cfg_ch = 3'd0;
        step();
        check("err_ch5_one_cycle", 32'(cfg_err), 32'h0);
        check("ready_ch0_nothing_stored", 32'(cfg_ready), 32'h1);

        repeat (2) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("sync_flag_zero", 32'(clk_flag), 32'h0);
        check("sync_out_zero", 32'(clk_out), 32'h0);
        repeat (4) step();
        check("sync_ch1_div5", 32'(clk_flag), 32'h02);
        step();
        check("sync_div6_coincident", 32'(clk_flag), 32'h1D);

        ch_en[2] = 1'b0;
        cfg_write(2, 3, 1'b1);
        step();
        ch_en[2] = 1'b1;
        count_flags(2, 20, cnt);
        check("oneshot_single", 32'(cnt), 32'd1);
        check("oneshot_idle_out", 32'(clk_out[2]), 32'h0);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        count_flags(2, 20, cnt);
        check("oneshot_rearm", 32'(cnt), 32'd1);

        repeat (2) step();
        cfg_write(0, 9, 1'b0);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_async_flag", 32'(clk_flag), 32'h0);
        check("rst_async_out", 32'(clk_out), 32'h0);
        check("rst_pend_cleared", 32'(cfg_ready), 32'h1);
        step();
        release_and_check_default("post_rst");

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 39) == 0) ch_en[i] = ~ch_en[i];
            sync_clr    = ($urandom_range(0, 29) == 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_ch      = CHW'($urandom_range(0, 7));
            cfg_oneshot = ($urandom_range(0, 2) == 0);
            p = $urandom_range(0, 99);
            if (p < 85)      cfg_div = CW'($urandom_range(0, 12));
            else if (p < 98) cfg_div = CW'($urandom_range(13, 40));
            else             cfg_div = 8'hFF;
            sys_rst = ($urandom_range(0, 799) == 0);
            step();
        end
        sys_rst = 1'b0;
        cfg_valid = 1'b0;
        sync_clr = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
